// File: rtl/softmax_max_stream.sv
// Softmax front end: buffers a streamed vector of NUM-lane beats, reduces it to its
// maximum, then replays the beats alongside that maximum. Optional macro: SOFTMAX_NAN_EN.
module softmax_max_stream #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned EXPWIDTH  = 5,
  parameter int unsigned NUM       = 4,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(DEPTH+1)-1:0]    num_beats,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATAWIDTH*NUM-1:0]      inp,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATAWIDTH*NUM-1:0]      outp,
  output logic [DATAWIDTH-1:0]          max_out,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
`ifdef SOFTMAX_NAN_EN
  ,
  output logic                          nan_flag
`endif
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW = DATAWIDTH * NUM;
  localparam int unsigned MW = DATAWIDTH - EXPWIDTH - 1;

  localparam logic [DATAWIDTH-1:0] NEG_INF = {1'b1, {EXPWIDTH{1'b1}}, {MW{1'b0}}};
`ifdef SOFTMAX_NAN_EN
  localparam logic [DATAWIDTH-1:0] QNAN = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(MW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_e;

  // Monotonic unsigned key: positives above negatives, +0 above -0.
  function automatic logic [DATAWIDTH-1:0] order_key(input logic [DATAWIDTH-1:0] x);
    return x[DATAWIDTH-1] ? ~x : (x | {1'b1, {(DATAWIDTH-1){1'b0}}});
  endfunction

`ifdef SOFTMAX_NAN_EN
  function automatic logic is_nan(input logic [DATAWIDTH-1:0] x);
    return (x[DATAWIDTH-2 -: EXPWIDTH] == {EXPWIDTH{1'b1}}) && (x[MW-1:0] != '0);
  endfunction
`endif

  state_e               state_q, state_d;
  logic [LW-1:0]        len_q, len_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATAWIDTH-1:0] max_q, max_d;
  logic                 done_q, done_d;
  logic                 wr_en_c;
  logic [BW-1:0]        buf_q [DEPTH];
  logic [DATAWIDTH-1:0] beat_max_c;
  logic [LW-1:0]        len_sel_c;
  logic                 last_wr_c;
  logic                 last_rd_c;
`ifdef SOFTMAX_NAN_EN
  logic                 nan_q, nan_d;
  logic                 beat_nan_c;
`endif

  // Lane reduction of the incoming beat; ties keep the lower lane.
  always_comb begin
    beat_max_c = inp[DATAWIDTH-1:0];
`ifdef SOFTMAX_NAN_EN
    beat_nan_c = 1'b0;
`endif
    for (int k = 0; k < NUM; k++) begin
      if (order_key(inp[DATAWIDTH*k +: DATAWIDTH]) > order_key(beat_max_c)) begin
        beat_max_c = inp[DATAWIDTH*k +: DATAWIDTH];
      end
`ifdef SOFTMAX_NAN_EN
      beat_nan_c = beat_nan_c | is_nan(inp[DATAWIDTH*k +: DATAWIDTH]);
`endif
    end
  end

  assign len_sel_c = (num_beats > LW'(DEPTH)) ? LW'(DEPTH) : num_beats;
  assign last_wr_c = (LW'(wr_ptr_q) == len_q - LW'(1));
  assign last_rd_c = (LW'(rd_ptr_q) == len_q - LW'(1));

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    max_d    = max_q;
    done_d   = 1'b0;
    wr_en_c  = 1'b0;
`ifdef SOFTMAX_NAN_EN
    nan_d    = nan_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && (num_beats != '0)) begin
          len_d    = len_sel_c;
          max_d    = NEG_INF;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = S_LOAD;
`ifdef SOFTMAX_NAN_EN
          nan_d    = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (order_key(beat_max_c) > order_key(max_q)) begin
            max_d = beat_max_c;
          end
`ifdef SOFTMAX_NAN_EN
          nan_d = nan_q | beat_nan_c;
`endif
          if (last_wr_c) begin
            rd_ptr_d = '0;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (last_rd_c) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      max_q    <= NEG_INF;
      done_q   <= 1'b0;
`ifdef SOFTMAX_NAN_EN
      nan_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      max_q    <= max_d;
      done_q   <= done_d;
`ifdef SOFTMAX_NAN_EN
      nan_q    <= nan_d;
`endif
    end
  end

  // Vector buffer is pure storage; it is never read outside DRAIN.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      buf_q[wr_ptr_q] <= inp;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign outp      = out_valid ? buf_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && last_rd_c;
`ifdef SOFTMAX_NAN_EN
  assign max_out   = out_valid ? (nan_q ? QNAN : max_q) : '0;
  assign nan_flag  = out_valid && nan_q;
`else
  assign max_out   = out_valid ? max_q : '0;
`endif

endmodule

// File: tb/tb_softmax_max_stream.sv
// Self-checking bench for softmax_max_stream: directed and random vectors against a
// sign-magnitude reference model; honours SOFTMAX_NAN_EN when defined.
module tb_softmax_max_stream;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  num_beats;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] inp;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] outp;
  logic [15:0] max_out;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef SOFTMAX_NAN_EN
  logic        nan_flag;
`endif

  int checks   = 0;
  int failures = 0;
  logic [63:0] beats [DEPTH];

  softmax_max_stream dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_beats (num_beats),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .max_out   (max_out),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef SOFTMAX_NAN_EN
    ,
    .nan_flag  (nan_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // a > b in real-number order; +0 counts above -0.
  function automatic bit fp_gt(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) return b[15];
    if (!a[15]) return a[14:0] > b[14:0];
    return a[14:0] < b[14:0];
  endfunction

  function automatic bit fp_isnan(input logic [15:0] a);
    return (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] l0, input logic [15:0] l1,
                                     input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [15:0] gen_lane();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFC00;
      3: return 16'h7C00;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic ref_model(input int len, output logic [15:0] em, output bit enan);
    logic [63:0] b;
    logic [15:0] lane;
    em   = 16'hFC00;
    enan = 1'b0;
    for (int i = 0; i < len; i++) begin
      b = beats[i];
      for (int k = 0; k < 4; k++) begin
        lane = b[16*k +: 16];
        if (fp_gt(lane, em)) em = lane;
        if (fp_isnan(lane)) enan = 1'b1;
      end
    end
`ifdef SOFTMAX_NAN_EN
    if (enan) em = 16'h7E00;
`endif
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_outp"}, outp, 64'(0));
    chk({tag, "_max_out"}, 64'(max_out), 64'(0));
    chk({tag, "_out_last"}, 64'(out_last), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
`ifdef SOFTMAX_NAN_EN
    chk({tag, "_nan_flag"}, 64'(nan_flag), 64'(0));
`endif
  endtask

  // rmode: 0 always ready, 1 random ready, 2 pattern 1,0,0,1,1 then ready.
  task automatic run_vec(input string tag, input int nb, input bit extra_start,
                         input int rmode, input int expected_max);
    int          len;
    int          idx;
    int          budget;
    bit          rdy;
    logic [15:0] em;
    bit          enan;
    bit          pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    len = (nb > DEPTH) ? DEPTH : nb;
    ref_model(len, em, enan);
    if (expected_max >= 0) chk({tag, "_refmodel"}, 64'(em), 64'(expected_max));

    start     = 1'b1;
    num_beats = 5'(nb);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_load"}, 64'(busy), 64'(1));
    chk({tag, "_out_valid_load"}, 64'(out_valid), 64'(0));

    for (int i = 0; i < len; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        inp      = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      inp      = beats[i];
      if (extra_start && i == 1) begin
        start     = 1'b1;
        num_beats = 5'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end

    in_valid = 1'b0;
    idx      = 0;
    budget   = 0;
    while (idx < len && budget < 200) begin
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) :
            (budget < 5) ? pat[budget] : 1'b1;
      out_ready = rdy;
      in_valid  = 1'($urandom_range(0, 1));
      inp       = {$urandom, $urandom};
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(1));
      chk({tag, "_in_ready_drain"}, 64'(in_ready), 64'(0));
      chk({tag, "_outp"}, outp, beats[idx]);
      chk({tag, "_max_out"}, 64'(max_out), 64'(em));
      chk({tag, "_out_last"}, 64'(out_last), 64'(idx == len - 1));
`ifdef SOFTMAX_NAN_EN
      chk({tag, "_nan_flag"}, 64'(nan_flag), 64'(enan));
`endif
      @(posedge clk); #1;
      if (rdy) idx++;
      budget++;
    end
    if (budget >= 200) chk({tag, "_drain_timeout"}, 64'(idx), 64'(len));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_out_valid_end"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    reset     = 1'b0;
    start     = 1'b0;
    num_beats = '0;
    in_valid  = 1'b0;
    inp       = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    beats[0] = mk(16'h3800, 16'h4040, 16'h4210, 16'h993e);
    run_vec("single", 1, 1'b0, 0, 16'h4210);

    beats[0] = mk(16'h3800, 16'h3800, 16'h3800, 16'h3800);
    beats[1] = mk(16'hC500, 16'h4040, 16'h0000, 16'h8000);
    beats[2] = mk(16'h993e, 16'h4210, 16'h4211, 16'hBC00);
    run_vec("three", 3, 1'b0, 2, 16'h4211);

    beats[0] = mk(16'hBC00, 16'hC000, 16'hC400, 16'hFC00);
    run_vec("allneg", 1, 1'b0, 0, 16'hBC00);

    beats[0] = mk(16'h8000, 16'h0000, 16'h8000, 16'h8000);
    run_vec("zeros", 1, 1'b0, 0, 16'h0000);

    beats[0] = mk(16'h3800, 16'h4040, 16'h7C01, 16'h4210);
`ifdef SOFTMAX_NAN_EN
    run_vec("nan", 1, 1'b0, 0, 16'h7E00);
`else
    run_vec("nan", 1, 1'b0, 0, 16'h7C01);
`endif

    // Zero-length start is ignored.
    start     = 1'b1;
    num_beats = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      chk("zerolen_busy", 64'(busy), 64'(0));
      chk("zerolen_out_valid", 64'(out_valid), 64'(0));
      chk("zerolen_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end

    for (int i = 0; i < DEPTH; i++) beats[i] = mk(gen_lane(), gen_lane(), gen_lane(), gen_lane());
    run_vec("clamp", DEPTH + 3, 1'b0, 1, -1);

    for (int i = 0; i < 4; i++) beats[i] = mk(gen_lane(), gen_lane(), gen_lane(), gen_lane());
    run_vec("restart_ignored", 4, 1'b1, 0, -1);

    // Asynchronous reset in the middle of beat 2 of a 4-beat load.
    beats[0] = mk(16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF);
    start     = 1'b1;
    num_beats = 5'd4;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    inp      = beats[0];
    @(posedge clk); #1;
    inp = mk(16'h7BFE, 16'h1, 16'h2, 16'h3);
    #3;
    reset = 1'b0;
    #1;
    chk_quiet("midreset");
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_quiet("midreset_hold");
    reset = 1'b1;
    @(posedge clk); #1;
    beats[0] = mk(16'hC000, 16'hB800, 16'hC400, 16'hC800);
    beats[1] = mk(16'hC100, 16'hBA00, 16'hFC00, 16'hC200);
    run_vec("after_reset", 2, 1'b0, 1, 16'hB800);

    for (int v = 0; v < 20; v++) begin
      nb = (v % 5 == 4) ? int'($urandom_range(DEPTH + 1, 31)) : int'($urandom_range(1, DEPTH));
      for (int i = 0; i < DEPTH; i++) beats[i] = mk(gen_lane(), gen_lane(), gen_lane(), gen_lane());
      run_vec("random", nb, 1'($urandom_range(0, 1)) && (nb >= 2), 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/softmax_max_stream.md
Name: softmax_max_stream

Overview:
- Front-end stage of the next-generation softmax datapath.
- Accepts a vector of IEEE-format floating-point elements streamed NUM lanes per beat, up to DEPTH beats.
- Buffers the whole vector while reducing it to its maximum.
- Replays the buffered beats alongside the final maximum, so the downstream subtract/exp stage can form x - max without the host presenting inputs twice.

Parameters:
- DATAWIDTH, 16, element width in bits; sign-magnitude IEEE layout (sign at MSB, exponent field of EXPWIDTH bits below it).
- EXPWIDTH, 5, exponent field width; used only for -inf and NaN encodings.
- NUM, 4, lanes per beat.
- DEPTH, 16, maximum beats per vector; buffer depth.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a vector; sampled only in IDLE
- num_beats  in  $clog2(DEPTH+1)  vector length in beats; latched on accepted start
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- inp  in  DATAWIDTH*NUM  input beat; lane k at [DATAWIDTH*(k+1)-1 : DATAWIDTH*k]
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat consumed when out_valid && out_ready
- outp  out  DATAWIDTH*NUM  replayed beat, same lane layout as inp
- max_out  out  DATAWIDTH  maximum over all lanes of all beats; stable throughout DRAIN
- out_last  out  1  high with the final output beat
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse the cycle after the final output handshake

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; counters cleared; running max = -inf; all outputs 0. Buffer contents are not reset.
- Reset mid-operation aborts the vector immediately. No done pulse is produced.
- Ordering: key(x) = x[MSB] ? ~x : (x | 1<<MSB); unsigned compare of keys.
  - +0 > -0.
  - Equal keys keep the earlier value.
  - -inf = sign 1, exponent all ones, mantissa 0 (16'hFC00 at defaults).
- Per beat: combinational NUM-lane compare tree, then compare with the running max register.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with num_beats=0: ignored, stays IDLE.
  - start=1 with num_beats>DEPTH: length clamped to DEPTH.
  - Otherwise: latch length, max <= -inf, wr_ptr <= 0, go to LOAD next cycle.
- LOAD:
  - in_ready=1.
  - Each handshake writes buffer[wr_ptr], updates max, increments wr_ptr.
  - On the handshake of beat length-1: go to DRAIN next cycle; in_ready drops in that cycle.
- DRAIN:
  - out_valid=1; outp = buffer[rd_ptr]; max_out = final max; out_last = (rd_ptr == length-1).
  - rd_ptr advances only on handshake; outp is held while out_ready=0.
  - After the last handshake: go to IDLE and pulse done.
- Latency: first out_valid is one cycle after the last input handshake. Throughput is 1 beat/cycle in each phase.
- start is ignored while busy=1.
- in_valid outside LOAD: no effect.
- out_ready outside DRAIN: no effect.

Optional Feature:
- Macro: SOFTMAX_NAN_EN
- Defined:
  - A NaN is exponent all ones with mantissa != 0.
  - Any NaN lane in the vector forces max_out to canonical qNaN: sign 0, exponent all ones, mantissa MSB 1 (16'h7E00 at defaults).
  - Adds output nan_flag (1 bit), high throughout DRAIN when a NaN was seen; 0 otherwise and 0 at reset.
- Undefined:
  - NaNs are ordered by key only: +NaN above +inf, -NaN below -inf.
  - No nan_flag port.

Test Plan:
- num_beats=1, one beat with lanes {3800, 4040, 4210, 993e} (lane0 first), out_ready=1 → one cycle later out_valid=1, outp equal to the input beat, max_out=4210, out_last=1; done pulses the next cycle.
- num_beats=3, beats {3800, 3800, 3800, 3800}, {C500, 4040, 0000, 8000}, {993e, 4210, 4211, BC00}, then out_ready toggled 1,0,0,1,1 → three beats replayed in order, held while out_ready=0; max_out=4211; out_last only on the third beat.
- All lanes negative {BC00, C000, C400, FC00}, num_beats=1 → max_out=BC00. Lanes {8000, 0000, 8000, 8000} → max_out=0000.
- start with num_beats=0 → busy stays 0, no out_valid. num_beats=DEPTH+3 → exactly DEPTH beats accepted and replayed. A second start pulse in LOAD → ignored.
- reset=0 asserted asynchronously during beat 2 of 4 in LOAD → all outputs 0 immediately; after release, a new 2-beat vector computes its own max with no carry-over.
- SOFTMAX_NAN_EN defined, one lane 7C01 among {3800, 4040, 4210} → max_out=7E00, nan_flag=1 through DRAIN. Same input without the macro → max_out=7C01.
